ga_issue_ctrl: RTL and testbench
================================

Name: ga_issue_ctrl

Overview:
Sits directly downstream of the GA-extended decoder in the ID stage and upstream of the GA execution unit. Accepts decoded GA instructions through a valid/ready handshake and tracks outstanding GA register writes in a scoreboard, stalling ID on RAW/WAW hazards. Issues operations in order, retires completions in order, and generates registered GA register-file writebacks. Also handles a status-op fence, a completion watchdog and sticky error reporting.

Parameters:
MaxOutstanding, 4, depth of in-order outstanding-op FIFO (power of 2, 2..8)
TimeoutCycles, 255, cycles without completion before the head op is force-retired (1..65535)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  decoder presents GA instruction (decoder ga_en_o qualified by ID valid)
id_ready_o  out  1  instruction accepted this cycle
ga_op_sel_i  in  ibex_pkg::ga_op_sel_e  decoded GA operation class
ga_funct3_i  in  3  function code
ga_funct7_i  in  7  extended function code
ga_reg_we_i  in  1  instruction writes GA register
ga_reg_raddr_a_i  in  5  GA source A
ga_reg_raddr_b_i  in  5  GA source B
ga_reg_waddr_i  in  5  GA destination
ex_valid_o  out  1  op presented to GA execution unit
ex_ready_i  in  1  execution unit accepts op
ex_op_sel_o / ex_funct3_o / ex_funct7_o / ex_raddr_a_o / ex_raddr_b_o / ex_waddr_o  out  as inputs  combinational pass-through of ID fields
ex_done_i  in  1  one-cycle pulse: oldest outstanding op completed
ex_err_i  in  1  qualifies ex_done_i: op faulted, suppress writeback
wb_we_o  out  1  GA register-file write enable (registered)
wb_waddr_o  out  5  GA register-file write address (registered)
busy_o  out  1  at least one op outstanding
err_proto_o  out  1  sticky: ex_done_i received with no op outstanding
err_timeout_o  out  1  sticky: watchdog force-retired an op
err_exec_o  out  1  sticky: op completed with ex_err_i
err_clear_i  in  1  clears all sticky errors

Behaviour:
- Reset: FIFO empty, scoreboard all zero, watchdog counter 0. wb_we_o=0, wb_waddr_o=0, busy_o=0, all err_* = 0.
- While rst_i is high, id_ready_o=0 and ex_valid_o=0.
- Hazard: scoreboard[raddr_a] | scoreboard[raddr_b] | (reg_we & scoreboard[waddr]). Register 0 is tracked like any other register.
- Issue-allowed: !hazard & FIFO not full & (op_sel != GA_OP_STATUS | FIFO empty).
- ex_valid_o = id_valid_i & issue-allowed. ex_valid_o never depends on ex_ready_i.
- id_ready_o = ex_valid_o & ex_ready_i. On that cycle: push {reg_we, waddr}; if reg_we, set scoreboard[waddr] at the clock edge.
- Completion, when ex_done_i=1 and FIFO is non-empty:
  - pop the head;
  - next cycle, wb_we_o = head.we & !ex_err_i and wb_waddr_o = head.waddr;
  - head's scoreboard bit clears at the end of that wb cycle;
  - a dependent instruction is accepted no earlier than done+2.
- If ex_err_i=1 at completion, set err_exec_o.
- Simultaneous push and pop in one cycle: occupancy is unchanged. A push to a full FIFO cannot occur because issue-allowed requires not full.
- ex_done_i with the FIFO empty: ignored, err_proto_o set.
- Watchdog: counter increments each cycle the FIFO is non-empty and ex_done_i=0. It resets to 0 on ex_done_i or when the FIFO is empty. When it reaches TimeoutCycles:
  - pop the head with no writeback;
  - clear the head's scoreboard bit next cycle;
  - set err_timeout_o;
  - counter to 0.
- A completion arriving in the same cycle as the timeout takes priority: normal retire, no error.
- err_clear_i clears the sticky bits. A new error event in the same cycle wins (bit stays set).
- busy_o = FIFO non-empty (registered occupancy != 0).
- Reset mid-operation discards all outstanding ops. A late ex_done_i afterwards sets err_proto_o.

Test Plan:
- Reset, then ARITH waddr=3, ex_ready_i=1 -> id_ready_o=1 same cycle, busy_o=1; ex_done_i 5 cycles later -> next cycle wb_we_o=1, wb_waddr_o=3, busy_o=0.
- ARITH waddr=5 outstanding, next ARITH raddr_a=5 -> ex_valid_o=0 until done; done at cycle T -> dependent accepted at T+2, not T+1.
- Issue 4 independent ops (waddr 1..4) with no completions -> 5th stalled (FIFO full); single done -> 5th accepted the following cycle, in-order wb of waddr 1.
- STATUS op with 2 outstanding -> held until both retire, then issued.
- TimeoutCycles=8, op waddr=7 with no done -> after 8 cycles: err_timeout_o=1, no wb, scoreboard[7] cleared; err_clear_i -> 0.
- ex_done_i with FIFO empty -> err_proto_o=1. ex_done_i+ex_err_i on STORE_MEM head -> wb_we_o stays 0, err_exec_o=1.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared decoder/GA type definitions used by the GA issue controller.
// Only the GA operation-class enum is needed by this block.
package ibex_pkg;

  typedef enum logic [2:0] {
    GA_OP_ARITH     = 3'd0,
    GA_OP_LOGIC     = 3'd1,
    GA_OP_LOAD_MEM  = 3'd2,
    GA_OP_STORE_MEM = 3'd3,
    GA_OP_STATUS    = 3'd4
  } ga_op_sel_e;

endpackage

// File: rtl/ga_issue_ctrl.sv
// GA issue controller: scoreboarded in-order issue of decoded GA ops, in-order
// retirement with registered writeback, status fence, watchdog and sticky errors.
module ga_issue_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  output logic       id_ready_o,
  input  ga_op_sel_e ga_op_sel_i,
  input  logic [2:0] ga_funct3_i,
  input  logic [6:0] ga_funct7_i,
  input  logic       ga_reg_we_i,
  input  logic [4:0] ga_reg_raddr_a_i,
  input  logic [4:0] ga_reg_raddr_b_i,
  input  logic [4:0] ga_reg_waddr_i,
  output logic       ex_valid_o,
  input  logic       ex_ready_i,
  output ga_op_sel_e ex_op_sel_o,
  output logic [2:0] ex_funct3_o,
  output logic [6:0] ex_funct7_o,
  output logic [4:0] ex_raddr_a_o,
  output logic [4:0] ex_raddr_b_o,
  output logic [4:0] ex_waddr_o,
  input  logic       ex_done_i,
  input  logic       ex_err_i,
  output logic       wb_we_o,
  output logic [4:0] wb_waddr_o,
  output logic       busy_o,
  output logic       err_proto_o,
  output logic       err_timeout_o,
  output logic       err_exec_o,
  input  logic       err_clear_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Each FIFO entry is {writes_reg, dest_addr}.
  logic [5:0]      fifo_mem_reg [MaxOutstanding];
  logic [PtrW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CntW-1:0] count_reg, count_next;
  logic [31:0]     scoreboard_reg, scoreboard_next;
  logic            clr_valid_reg;
  logic [4:0]      clr_addr_reg;
  logic [15:0]     wdog_reg;
  logic            wb_we_reg;
  logic [4:0]      wb_waddr_reg;
  logic            err_proto_reg, err_timeout_reg, err_exec_reg;

  logic       fifo_empty, fifo_full, hazard, issue_allowed;
  logic       push, done_pop, timeout_pop, pop;
  logic [5:0] head;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CntW'(MaxOutstanding));

  assign hazard = scoreboard_reg[ga_reg_raddr_a_i] | scoreboard_reg[ga_reg_raddr_b_i] |
                  (ga_reg_we_i & scoreboard_reg[ga_reg_waddr_i]);

  // A status op acts as a fence: it only issues into an empty pipeline.
  assign issue_allowed = ~hazard & ~fifo_full &
                         ((ga_op_sel_i != GA_OP_STATUS) | fifo_empty);

  assign ex_valid_o = id_valid_i & issue_allowed & ~rst_i;
  assign push       = ex_valid_o & ex_ready_i;
  assign id_ready_o = push;

  assign ex_op_sel_o  = ga_op_sel_i;
  assign ex_funct3_o  = ga_funct3_i;
  assign ex_funct7_o  = ga_funct7_i;
  assign ex_raddr_a_o = ga_reg_raddr_a_i;
  assign ex_raddr_b_o = ga_reg_raddr_b_i;
  assign ex_waddr_o   = ga_reg_waddr_i;

  assign head        = fifo_mem_reg[rd_ptr_reg];
  assign done_pop    = ex_done_i & ~fifo_empty;
  assign timeout_pop = ~fifo_empty & ~ex_done_i & (wdog_reg == 16'(TimeoutCycles - 1));
  assign pop         = done_pop | timeout_pop;
  assign count_next  = count_reg + CntW'(push) - CntW'(pop);

  // Set on accept wins over a pending clear; WAW hazard keeps the two apart anyway.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sb
    assign scoreboard_next[gi] =
        (push & ga_reg_we_i & (ga_reg_waddr_i == 5'(gi))) |
        (scoreboard_reg[gi] & ~(clr_valid_reg & (clr_addr_reg == 5'(gi))));
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_reg[wr_ptr_reg] <= {ga_reg_we_i, ga_reg_waddr_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      scoreboard_reg  <= '0;
      clr_valid_reg   <= 1'b0;
      clr_addr_reg    <= '0;
      wdog_reg        <= '0;
      wb_we_reg       <= 1'b0;
      wb_waddr_reg    <= '0;
      err_proto_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_exec_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_next;
      scoreboard_reg <= scoreboard_next;
      // The retired head's bit is released one cycle later, during the wb cycle.
      clr_valid_reg  <= pop & head[5];
      clr_addr_reg   <= head[4:0];
      wb_we_reg      <= done_pop & head[5] & ~ex_err_i;
      if (done_pop) wb_waddr_reg <= head[4:0];
      wdog_reg <= (fifo_empty | ex_done_i | timeout_pop) ? '0 : wdog_reg + 16'd1;
      err_proto_reg   <= (err_proto_reg & ~err_clear_i) | (ex_done_i & fifo_empty);
      err_timeout_reg <= (err_timeout_reg & ~err_clear_i) | timeout_pop;
      err_exec_reg    <= (err_exec_reg & ~err_clear_i) | (done_pop & ex_err_i);
    end
  end

  assign wb_we_o       = wb_we_reg;
  assign wb_waddr_o    = wb_waddr_reg;
  assign busy_o        = ~fifo_empty;
  assign err_proto_o   = err_proto_reg;
  assign err_timeout_o = err_timeout_reg;
  assign err_exec_o    = err_exec_reg;

endmodule

// File: tb/tb_ga_issue_ctrl.sv
// Bench for ga_issue_ctrl: directed scenarios then random traffic, all checked
// against a queue/release-time reference model of the issue rules.
module tb_ga_issue_ctrl;
  import ibex_pkg::*;

  localparam int TO    = 8;
  localparam int DEPTH = 4;
  localparam int INF   = 32'h7fffffff;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i, id_ready_o;
  ga_op_sel_e ga_op_sel_i, ex_op_sel_o;
  logic [2:0] ga_funct3_i, ex_funct3_o;
  logic [6:0] ga_funct7_i, ex_funct7_o;
  logic       ga_reg_we_i;
  logic [4:0] ga_reg_raddr_a_i, ga_reg_raddr_b_i, ga_reg_waddr_i;
  logic       ex_valid_o, ex_ready_i;
  logic [4:0] ex_raddr_a_o, ex_raddr_b_o, ex_waddr_o;
  logic       ex_done_i, ex_err_i;
  logic       wb_we_o;
  logic [4:0] wb_waddr_o;
  logic       busy_o, err_proto_o, err_timeout_o, err_exec_o, err_clear_i;

  always #5 clk_i = ~clk_i;

  ga_issue_ctrl #(.MaxOutstanding(DEPTH), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .ga_op_sel_i(ga_op_sel_i), .ga_funct3_i(ga_funct3_i), .ga_funct7_i(ga_funct7_i),
    .ga_reg_we_i(ga_reg_we_i), .ga_reg_raddr_a_i(ga_reg_raddr_a_i),
    .ga_reg_raddr_b_i(ga_reg_raddr_b_i), .ga_reg_waddr_i(ga_reg_waddr_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_op_sel_o(ex_op_sel_o), .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
    .ex_raddr_a_o(ex_raddr_a_o), .ex_raddr_b_o(ex_raddr_b_o), .ex_waddr_o(ex_waddr_o),
    .ex_done_i(ex_done_i), .ex_err_i(ex_err_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .busy_o(busy_o),
    .err_proto_o(err_proto_o), .err_timeout_o(err_timeout_o), .err_exec_o(err_exec_o),
    .err_clear_i(err_clear_i)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: outstanding ops in order, and the cycle each register frees up.
  typedef struct {logic we; logic [4:0] waddr;} op_t;
  op_t        q[$];
  int         free_at[32];
  int         cyc, idle;
  logic       m_wb_we;
  logic [4:0] m_wb_waddr;
  logic       m_proto, m_tmo, m_exec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit reg_free(input logic [4:0] r);
    return cyc >= free_at[r];
  endfunction

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 32; r++) free_at[r] = 0;
    cyc = 0; idle = 0;
    m_wb_we = 1'b0; m_wb_waddr = '0;
    m_proto = 1'b0; m_tmo = 1'b0; m_exec = 1'b0;
  endtask

  task automatic set_idle();
    id_valid_i = 1'b0; ga_op_sel_i = GA_OP_ARITH; ga_funct3_i = '0; ga_funct7_i = '0;
    ga_reg_we_i = 1'b0; ga_reg_raddr_a_i = '0; ga_reg_raddr_b_i = '0; ga_reg_waddr_i = '0;
    ex_ready_i = 1'b1; ex_done_i = 1'b0; ex_err_i = 1'b0; err_clear_i = 1'b0;
  endtask

  task automatic drive_op(input ga_op_sel_e op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic we, input logic [4:0] wa);
    id_valid_i = 1'b1; ga_op_sel_i = op; ga_reg_raddr_a_i = ra; ga_reg_raddr_b_i = rb;
    ga_reg_we_i = we; ga_reg_waddr_i = wa;
    ga_funct3_i = 3'($urandom_range(0, 7)); ga_funct7_i = 7'($urandom_range(0, 127));
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit   hz, exp_valid, exp_ready, nonempty, done_ev, tmo_ev;
    op_t  h;
    hz = !reg_free(ga_reg_raddr_a_i) || !reg_free(ga_reg_raddr_b_i) ||
         (ga_reg_we_i && !reg_free(ga_reg_waddr_i));
    exp_valid = id_valid_i && !hz && (q.size() < DEPTH) &&
                (ga_op_sel_i != GA_OP_STATUS || q.size() == 0);
    exp_ready = exp_valid && ex_ready_i;
    @(negedge clk_i);
    chk("ex_valid", 32'(ex_valid_o), 32'(exp_valid));
    chk("id_ready", 32'(id_ready_o), 32'(exp_ready));
    chk("wb_we", 32'(wb_we_o), 32'(m_wb_we));
    if (m_wb_we) chk("wb_waddr", 32'(wb_waddr_o), 32'(m_wb_waddr));
    chk("busy", 32'(busy_o), 32'(q.size() != 0));
    chk("err_proto", 32'(err_proto_o), 32'(m_proto));
    chk("err_timeout", 32'(err_timeout_o), 32'(m_tmo));
    chk("err_exec", 32'(err_exec_o), 32'(m_exec));
    chk("pass_fields", {ex_op_sel_o, ex_funct3_o, ex_funct7_o, ex_raddr_a_o, ex_raddr_b_o, ex_waddr_o},
        {ga_op_sel_i, ga_funct3_i, ga_funct7_i, ga_reg_raddr_a_i, ga_reg_raddr_b_i, ga_reg_waddr_i});
    @(posedge clk_i);
    nonempty = q.size() > 0;
    done_ev  = ex_done_i && nonempty;
    tmo_ev   = nonempty && !ex_done_i && (idle + 1 == TO);
    m_wb_we  = 1'b0;
    if (done_ev || tmo_ev) begin
      h = q.pop_front();
      if (h.we) free_at[h.waddr] = cyc + 2;
      if (done_ev) begin
        m_wb_we = h.we && !ex_err_i;
        m_wb_waddr = h.waddr;
      end
    end
    m_proto = (m_proto && !err_clear_i) || (ex_done_i && !nonempty);
    m_tmo   = (m_tmo && !err_clear_i) || tmo_ev;
    m_exec  = (m_exec && !err_clear_i) || (done_ev && ex_err_i);
    idle    = (!nonempty || ex_done_i || tmo_ev) ? 0 : idle + 1;
    if (exp_ready) begin
      q.push_back('{we: ga_reg_we_i, waddr: ga_reg_waddr_i});
      if (ga_reg_we_i) free_at[ga_reg_waddr_i] = INF;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive_op(GA_OP_ARITH, 5'd1, 5'd2, 1'b1, 5'd3);
    ex_ready_i = 1'b1; ex_done_i = 1'b0; ex_err_i = 1'b0; err_clear_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_id_ready", 32'(id_ready_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    set_idle();
    chk("rst_wb", {wb_we_o, wb_waddr_o, busy_o}, 32'd0);
    chk("rst_errs", {err_proto_o, err_timeout_o, err_exec_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    set_idle();
    model_reset();
    do_reset();
    do_reset();

    // Single op: accept, busy, completion five cycles later, writeback of r3.
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd3); step();
    set_idle();
    for (int i = 0; i < 4; i++) step();
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0;
    chk("s1_wb", {wb_we_o, wb_waddr_o, busy_o}, {1'b1, 5'd3, 1'b0});
    step();

    // RAW: dependent of r5 held until two cycles after done.
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd5); step();
    drive_op(GA_OP_ARITH, 5'd5, 5'd1, 1'b1, 5'd6);
    for (int i = 0; i < 3; i++) step();
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0;
    step(); step();
    set_idle(); ex_done_i = 1'b1; step(); ex_done_i = 1'b0; step();

    // Fill the FIFO, fifth op waits for a single completion.
    for (int i = 1; i <= 4; i++) begin
      drive_op(GA_OP_LOGIC, 5'd0, 5'd0, 1'b1, 5'(i)); step();
    end
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd8); step();
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0;
    chk("s3_wb1", {wb_we_o, wb_waddr_o}, {1'b1, 5'd1});
    step();
    set_idle(); ex_done_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ex_done_i = 1'b0; step();

    // Status fence behind two outstanding ops.
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd9); step();
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd10); step();
    drive_op(GA_OP_STATUS, 5'd0, 5'd0, 1'b0, 5'd0); step();
    ex_done_i = 1'b1; step(); step(); ex_done_i = 1'b0;
    step();
    set_idle(); ex_done_i = 1'b1; step(); ex_done_i = 1'b0; step();

    // Watchdog force-retire of r7, then release, then sticky clear.
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd7); step();
    set_idle();
    for (int i = 0; i < TO + 1; i++) step();
    chk("s5_tmo", {err_timeout_o, wb_we_o, busy_o}, {1'b1, 1'b0, 1'b0});
    drive_op(GA_OP_ARITH, 5'd7, 5'd0, 1'b1, 5'd7); step();
    set_idle(); err_clear_i = 1'b1; step(); err_clear_i = 1'b0;
    chk("s5_clear", 32'(err_timeout_o), 32'd0);
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0; step();

    // Completion on the timeout cycle wins: normal retire of r11.
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd11); step();
    set_idle();
    for (int i = 0; i < TO - 1; i++) step();
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0;
    chk("s6_prio", {wb_we_o, wb_waddr_o, err_timeout_o}, {1'b1, 5'd11, 1'b0});

    // Protocol error on empty FIFO, exec error on a store head.
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0; step();
    chk("s7_proto", 32'(err_proto_o), 32'd1);
    drive_op(GA_OP_STORE_MEM, 5'd2, 5'd3, 1'b1, 5'd12); step();
    set_idle(); ex_done_i = 1'b1; ex_err_i = 1'b1; step();
    ex_done_i = 1'b0; ex_err_i = 1'b0;
    chk("s7_exec", {wb_we_o, err_exec_o}, {1'b0, 1'b1});
    step();

    // Reset with ops in flight; a late done is then a protocol error.
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd13); step();
    drive_op(GA_OP_ARITH, 5'd0, 5'd0, 1'b1, 5'd14); step();
    do_reset();
    ex_done_i = 1'b1; step(); ex_done_i = 1'b0; step();
    chk("s8_late_done", {err_proto_o, busy_o}, {1'b1, 1'b0});

    // Random traffic with occasional completion droughts to provoke timeouts.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset();
      id_valid_i       = ($urandom_range(0, 99) < 60);
      ga_op_sel_i      = ga_op_sel_e'(3'($urandom_range(0, 4)));
      ga_funct3_i      = 3'($urandom_range(0, 7));
      ga_funct7_i      = 7'($urandom_range(0, 127));
      ga_reg_raddr_a_i = 5'($urandom_range(0, 7));
      ga_reg_raddr_b_i = 5'($urandom_range(0, 7));
      ga_reg_waddr_i   = 5'($urandom_range(0, 7));
      ga_reg_we_i      = ($urandom_range(0, 3) != 0);
      ex_ready_i       = ($urandom_range(0, 3) != 0);
      ex_done_i        = ((i % 100) < 85) && ($urandom_range(0, 99) < 35);
      ex_err_i         = ex_done_i && ($urandom_range(0, 9) == 0);
      err_clear_i      = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
